color_pattern_gen: RTL and testbench
====================================

Name: color_pattern_gen

Overview:
Parametrised test-pattern source for the HDMI/RGB display path; successor to the fixed 4x2 colour-block generator.
- Consumes pixel addresses and a data request from the display timing controller.
- Returns a registered 24-bit RGB pixel with a valid flag.
- Supports a configurable row/column grid, four pattern modes, per-frame horizontal scrolling and a frame counter.

Parameters:
- DISP_WIDTH, 800: active pixels per line.
- DISP_HEIGHT, 480: active lines per frame.
- NUM_ROWS, 4: grid rows (1..8).
- NUM_COLS, 2: grid columns (1..8).
- SCROLL_STEP, 1: pixels added to the scroll offset per frame; must be less than DISP_WIDTH.

Ports:
- clk  input  1  pixel clock.
- reset_n  input  1  asynchronous active-low reset.
- disp_h_addr  input  12  current pixel column.
- disp_v_addr  input  12  current pixel row.
- disp_data_req  input  1  timing controller requests a pixel this cycle.
- mode  input  2  pattern select; sampled only at frame start.
- scroll_en  input  1  enables per-frame scroll; sampled only at frame start.
- disp_data  output  24  RGB888 pixel, {R,G,B}.
- disp_data_vld  output  1  disp_data is valid for the request issued 2 cycles earlier.
- frame_cnt  output  16  number of frame starts since reset.

Behaviour:
- Frame start (fs): disp_data_req=1 && disp_h_addr==0 && disp_v_addr==0.
- Reset (asynchronous, takes effect immediately, including mid-frame): disp_data=0, disp_data_vld=0, frame_cnt=0, scroll offset=0, latched mode=0, all pipeline valid bits=0.
- On fs:
  - mode_r <= mode.
  - If scroll_en=1: offset <= (offset+SCROLL_STEP >= DISP_WIDTH) ? offset+SCROLL_STEP-DISP_WIDTH : offset+SCROLL_STEP. If scroll_en=0, the offset holds.
  - frame_cnt increments and wraps from 0xFFFF to 0.
- The new mode and offset apply to the fs pixel itself (stage-1 bypass of the next-value logic). Mid-frame changes to mode or scroll_en have no effect until the next fs.
- Stage 1 (register):
  - eff_h = h+offset; if eff_h >= DISP_WIDTH, subtract DISP_WIDTH. Use 13-bit intermediate arithmetic.
  - Register eff_h, v, req, an in_range flag (h<DISP_WIDTH && v<DISP_HEIGHT) and the effective mode.
- Stage 2 (register):
  - Row index r: largest i with v >= i*(DISP_HEIGHT/NUM_ROWS).
  - Column index c: largest j with eff_h >= j*(DISP_WIDTH/NUM_COLS).
  - Boundaries are elaboration-time constants; the last row/column absorbs any remainder.
  - Bar index k = largest n (0..7) with eff_h >= n*(DISP_WIDTH/8).
  - Pixel colour is then selected by mode (below).
- Modes:
  - 0 GRID: palette[(r*NUM_COLS+c) mod 8].
  - 1 VBARS: palette[k].
  - 2 CHECKER: (r^c)[0] ? WHITE : BLACK.
  - 3 RAMP: each channel = {k,k,k[2:1]} (k=0 gives 0x00, k=7 gives 0xFF).
- Palette, indices 0..7: BLACK 000000, BLUE 0000FF, RED FF0000, PURPLE FF00FF, GREEN 00FF00, CYAN 00FFFF, YELLOW FFFF00, WHITE FFFFFF.
- Output rules:
  - Latency is exactly 2 clk cycles from request to output; throughput is 1 pixel per clock; there is no backpressure.
  - disp_data_vld = req delayed 2 cycles.
  - When vld=0, disp_data=000000.
  - A request with an address outside the active area gives 000000 with vld=1.
- Idle: with disp_data_req low, the offset, mode and counter are unchanged.

Decomposition:
- Package color_pattern_pkg: the eight palette constants, mode encodings (MODE_GRID=0, MODE_VBARS=1, MODE_CHECKER=2, MODE_RAMP=3) and the palette lookup function.
- Sub-module grid_index: parameters RANGE and SEGMENTS; input a 12-bit address; output a 3-bit segment index (purely combinational comparator chain).
  - Instantiated three times: rows, columns, and the 8 bars.

Test Plan:
1. Defaults, mode=0, scroll off; requests at (0,0), (400,0), (399,120), (799,479) -> two cycles later, vld=1 with 000000, 0000FF, FF0000, FFFFFF.
2. mode=1 latched by fs; h=99 -> 000000, h=100 -> 0000FF, h=700 -> FFFFFF. mode=2 latched by a later fs; (0,0) -> 000000, (400,0) -> FFFFFF, (400,120) -> 000000.
3. mode=3; h=0 -> 000000, h=300 (k=3) -> 6D6D6D, h=799 -> FFFFFF.
4. Scroll: scroll_en=1, mode=0, 3 fs; offset=3 and frame_cnt=3; h=397,v=0 -> 0000FF; h=799,v=0 -> eff_h=2 -> 000000. Then scroll_en=0 for 1 fs -> offset stays 3.
5. Change mode 0->1 at v=100: pixels are still grid colours until the next fs; the fs pixel at (0,0) and onwards use bars. Also: requests with req=0 -> vld=0, data=000000; h=800 with req=1 -> 000000 with vld=1.
6. Assert reset_n low mid-frame between clock edges -> disp_data=0, vld=0, frame_cnt=0 immediately. After release, the first fs gives offset=SCROLL_STEP if scroll_en=1.

Source files
------------

// File: rtl/color_pattern_pkg.sv
// Shared constants for the colour test-pattern source: RGB888 palette,
// pattern-mode encodings and the palette lookup used by the pixel stage.
// No ports; imported by color_pattern_gen.
package color_pattern_pkg;

  localparam logic [23:0] BLACK  = 24'h000000;
  localparam logic [23:0] BLUE   = 24'h0000FF;
  localparam logic [23:0] RED    = 24'hFF0000;
  localparam logic [23:0] PURPLE = 24'hFF00FF;
  localparam logic [23:0] GREEN  = 24'h00FF00;
  localparam logic [23:0] CYAN   = 24'h00FFFF;
  localparam logic [23:0] YELLOW = 24'hFFFF00;
  localparam logic [23:0] WHITE  = 24'hFFFFFF;

  localparam logic [1:0] MODE_GRID    = 2'd0;
  localparam logic [1:0] MODE_VBARS   = 2'd1;
  localparam logic [1:0] MODE_CHECKER = 2'd2;
  localparam logic [1:0] MODE_RAMP    = 2'd3;

  function automatic logic [23:0] palette(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = BLACK;
      3'd1:    rgb = BLUE;
      3'd2:    rgb = RED;
      3'd3:    rgb = PURPLE;
      3'd4:    rgb = GREEN;
      3'd5:    rgb = CYAN;
      3'd6:    rgb = YELLOW;
      default: rgb = WHITE;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/grid_index.sv
// Purpose: map an address onto one of SEGMENTS equal slices of RANGE; the
// last slice absorbs the remainder. Latency: combinational. Backpressure: none.
// Ports: i_addr (12-bit address in), o_idx (3-bit slice index out).
module grid_index #(
  parameter int RANGE    = 800,
  parameter int SEGMENTS = 2
) (
  input  logic [11:0] i_addr,
  output logic [2:0]  o_idx
);

  localparam int SEG = RANGE / SEGMENTS;

  // Boundaries are elaboration-time constants, so this unrolls into a
  // comparator chain; the highest boundary passed wins.
  always_comb begin
    o_idx = 3'd0;
    for (int i = 1; i < SEGMENTS; i++) begin
      if (int'(i_addr) >= i * SEG) o_idx = 3'(i);
    end
  end

endmodule

// File: rtl/color_pattern_gen.sv
// Purpose: test-pattern pixel source (grid / bars / checker / ramp) with scroll.
// Latency: 2 clk from disp_data_req to disp_data/disp_data_vld, 1 pixel/clk.
// Backpressure: none; every request produces exactly one output beat.
// Ports: clk, reset_n (async active-low); disp_h_addr/disp_v_addr/disp_data_req
// from the timing controller; mode, scroll_en sampled at frame start;
// disp_data {R,G,B}, disp_data_vld, frame_cnt (frame starts since reset).
module color_pattern_gen #(
  parameter int DISP_WIDTH  = 800,
  parameter int DISP_HEIGHT = 480,
  parameter int NUM_ROWS    = 4,
  parameter int NUM_COLS    = 2,
  parameter int SCROLL_STEP = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] disp_h_addr,
  input  logic [11:0] disp_v_addr,
  input  logic        disp_data_req,
  input  logic [1:0]  mode,
  input  logic        scroll_en,
  output logic [23:0] disp_data,
  output logic        disp_data_vld,
  output logic [15:0] frame_cnt
);

  import color_pattern_pkg::*;

  localparam logic [12:0] WIDTH13 = 13'(DISP_WIDTH);

  // Frame-level state
  logic [11:0] r_offset;
  logic [1:0]  r_mode;
  logic [15:0] r_frame_cnt;

  // Stage 1
  logic [11:0] r1_eff_h;
  logic [11:0] r1_v;
  logic        r1_req;
  logic        r1_in_range;
  logic [1:0]  r1_mode;

  // Stage 2 / output
  logic [23:0] r_data;
  logic        r_vld;

  logic        w_fs;
  logic [12:0] w_off_sum;
  logic [11:0] w_off_nxt;
  logic [11:0] w_off_eff;
  logic [1:0]  w_mode_eff;
  logic [12:0] w_h_sum;
  logic [11:0] w_eff_h;
  logic        w_in_range;
  logic [2:0]  w_row;
  logic [2:0]  w_col;
  logic [2:0]  w_bar;
  logic [6:0]  w_grid_lin;
  logic [7:0]  w_ramp;
  logic [23:0] w_pix;

  assign w_fs = disp_data_req && (disp_h_addr == 12'd0) && (disp_v_addr == 12'd0);

  assign w_off_sum = {1'b0, r_offset} + 13'(SCROLL_STEP);
  assign w_off_nxt = (w_off_sum >= WIDTH13) ? 12'(w_off_sum - WIDTH13) : w_off_sum[11:0];

  // The frame-start pixel already uses the freshly selected mode and offset,
  // so bypass the registers with their next values on fs.
  assign w_off_eff  = (w_fs && scroll_en) ? w_off_nxt : r_offset;
  assign w_mode_eff = w_fs ? mode : r_mode;

  // Offset is always < DISP_WIDTH, so one conditional subtract wraps the sum.
  assign w_h_sum    = {1'b0, disp_h_addr} + {1'b0, w_off_eff};
  assign w_eff_h    = (w_h_sum >= WIDTH13) ? 12'(w_h_sum - WIDTH13) : w_h_sum[11:0];
  assign w_in_range = (disp_h_addr < 12'(DISP_WIDTH)) && (disp_v_addr < 12'(DISP_HEIGHT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_offset    <= '0;
      r_mode      <= MODE_GRID;
      r_frame_cnt <= '0;
    end else if (w_fs) begin
      r_offset    <= w_off_eff;
      r_mode      <= mode;
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1_eff_h    <= '0;
      r1_v        <= '0;
      r1_req      <= 1'b0;
      r1_in_range <= 1'b0;
      r1_mode     <= MODE_GRID;
    end else begin
      r1_eff_h    <= w_eff_h;
      r1_v        <= disp_v_addr;
      r1_req      <= disp_data_req;
      r1_in_range <= w_in_range;
      r1_mode     <= w_mode_eff;
    end
  end

  grid_index #(.RANGE(DISP_HEIGHT), .SEGMENTS(NUM_ROWS)) u_rows (
    .i_addr (r1_v),
    .o_idx  (w_row)
  );

  grid_index #(.RANGE(DISP_WIDTH), .SEGMENTS(NUM_COLS)) u_cols (
    .i_addr (r1_eff_h),
    .o_idx  (w_col)
  );

  grid_index #(.RANGE(DISP_WIDTH), .SEGMENTS(8)) u_bars (
    .i_addr (r1_eff_h),
    .o_idx  (w_bar)
  );

  // Only the low three bits select the palette entry (mod 8).
  assign w_grid_lin = 7'(w_row) * 7'(NUM_COLS) + 7'(w_col);
  // Replicating the 3-bit bar index spreads 0..7 evenly over 0x00..0xFF.
  assign w_ramp     = {w_bar, w_bar, w_bar[2:1]};

  always_comb begin
    w_pix = BLACK;
    if (r1_in_range) begin
      case (r1_mode)
        MODE_GRID:    w_pix = palette(w_grid_lin[2:0]);
        MODE_VBARS:   w_pix = palette(w_bar);
        MODE_CHECKER: w_pix = (w_row[0] ^ w_col[0]) ? WHITE : BLACK;
        default:      w_pix = {w_ramp, w_ramp, w_ramp};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_data <= r1_req ? w_pix : 24'h000000;
      r_vld  <= r1_req;
    end
  end

  assign disp_data     = r_data;
  assign disp_data_vld = r_vld;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_color_pattern_gen.sv
// Directed self-checking bench for color_pattern_gen (default parameters).
module tb_color_pattern_gen;

  logic        clk;
  logic        reset_n;
  logic [11:0] disp_h_addr;
  logic [11:0] disp_v_addr;
  logic        disp_data_req;
  logic [1:0]  mode;
  logic        scroll_en;
  logic [23:0] disp_data;
  logic        disp_data_vld;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;

  color_pattern_gen dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .disp_h_addr   (disp_h_addr),
    .disp_v_addr   (disp_v_addr),
    .disp_data_req (disp_data_req),
    .mode          (mode),
    .scroll_en     (scroll_en),
    .disp_data     (disp_data),
    .disp_data_vld (disp_data_vld),
    .frame_cnt     (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one cycle of inputs, return 1 time unit after the capturing edge.
  task automatic drive(input logic req, input logic [11:0] h, input logic [11:0] v);
    disp_data_req = req;
    disp_h_addr   = h;
    disp_v_addr   = v;
    @(posedge clk);
    #1;
  endtask

  // Single request followed by an idle cycle; result visible after the 2nd edge.
  task automatic pix(input string tag, input logic [11:0] h, input logic [11:0] v,
                     input logic [23:0] exp);
    drive(1'b1, h, v);
    drive(1'b0, 12'd0, 12'd0);
    chk({tag, ".vld"}, {31'd0, disp_data_vld}, 32'd1);
    chk({tag, ".dat"}, {8'd0, disp_data}, {8'd0, exp});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 12'd0, 12'd0);
    drive(1'b0, 12'd0, 12'd0);
    reset_n = 1'b1;
    drive(1'b0, 12'd0, 12'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    disp_h_addr = '0;
    disp_v_addr = '0;
    disp_data_req = 1'b0;
    mode = 2'd0;
    scroll_en = 1'b0;
    drive(1'b0, 12'd0, 12'd0);
    drive(1'b0, 12'd0, 12'd0);
    chk("rst.vld", {31'd0, disp_data_vld}, 32'd0);
    chk("rst.dat", {8'd0, disp_data}, 32'd0);
    chk("rst.fcnt", {16'd0, frame_cnt}, 32'd0);
    reset_n = 1'b1;
    drive(1'b0, 12'd0, 12'd0);

    // 1: grid, back-to-back requests (throughput 1/clk, latency 2)
    drive(1'b1, 12'd0, 12'd0);
    drive(1'b1, 12'd400, 12'd0);
    chk("t1.a", {7'd0, disp_data_vld, disp_data}, {8'h01, 24'h000000});
    drive(1'b1, 12'd399, 12'd120);
    chk("t1.b", {7'd0, disp_data_vld, disp_data}, {8'h01, 24'h0000FF});
    drive(1'b1, 12'd799, 12'd479);
    chk("t1.c", {7'd0, disp_data_vld, disp_data}, {8'h01, 24'hFF0000});
    drive(1'b0, 12'd0, 12'd0);
    chk("t1.d", {7'd0, disp_data_vld, disp_data}, {8'h01, 24'hFFFFFF});
    drive(1'b0, 12'd0, 12'd0);
    chk("t1.idle", {7'd0, disp_data_vld, disp_data}, 32'd0);
    chk("t1.fcnt", {16'd0, frame_cnt}, 32'd1);

    // 2: vertical bars, then checker
    mode = 2'd1;
    pix("t2.fs1", 12'd0, 12'd0, 24'h000000);
    mode = 2'd0;
    pix("t2.h99", 12'd99, 12'd0, 24'h000000);
    pix("t2.h100", 12'd100, 12'd0, 24'h0000FF);
    pix("t2.h700", 12'd700, 12'd0, 24'hFFFFFF);
    mode = 2'd2;
    pix("t2.fs2", 12'd0, 12'd0, 24'h000000);
    pix("t2.ck400", 12'd400, 12'd0, 24'hFFFFFF);
    pix("t2.ck400_120", 12'd400, 12'd120, 24'h000000);

    // 3: ramp
    mode = 2'd3;
    pix("t3.h0", 12'd0, 12'd0, 24'h000000);
    pix("t3.h300", 12'd300, 12'd0, 24'h6D6D6D);
    pix("t3.h799", 12'd799, 12'd0, 24'hFFFFFF);
    chk("t3.fcnt", {16'd0, frame_cnt}, 32'd4);

    // 4: scrolling from a clean reset
    mode = 2'd0;
    do_reset();
    scroll_en = 1'b1;
    pix("t4.fs1", 12'd0, 12'd0, 24'h000000);
    pix("t4.fs2", 12'd0, 12'd0, 24'h000000);
    pix("t4.fs3", 12'd0, 12'd0, 24'h000000);
    chk("t4.fcnt3", {16'd0, frame_cnt}, 32'd3);
    scroll_en = 1'b0;
    pix("t4.h397", 12'd397, 12'd0, 24'h0000FF);
    pix("t4.h396", 12'd396, 12'd0, 24'h000000);
    pix("t4.h799", 12'd799, 12'd0, 24'h000000);
    pix("t4.fs4", 12'd0, 12'd0, 24'h000000);
    chk("t4.fcnt4", {16'd0, frame_cnt}, 32'd4);
    pix("t4.hold396", 12'd396, 12'd0, 24'h000000);
    pix("t4.hold397", 12'd397, 12'd0, 24'h0000FF);

    // 5: mid-frame mode change ignored until next fs (offset still 3)
    mode = 2'd1;
    pix("t5.mid103", 12'd100, 12'd100, 24'h000000);
    pix("t5.mid400", 12'd397, 12'd100, 24'h0000FF);
    pix("t5.fs", 12'd0, 12'd0, 24'h000000);
    pix("t5.bar4", 12'd397, 12'd100, 24'h00FF00);
    drive(1'b0, 12'd397, 12'd100);
    drive(1'b0, 12'd397, 12'd100);
    chk("t5.noreq", {7'd0, disp_data_vld, disp_data}, 32'd0);
    pix("t5.h800", 12'd800, 12'd0, 24'h000000);
    pix("t5.v480", 12'd397, 12'd480, 24'h000000);
    pix("t5.h897", 12'd897, 12'd0, 24'h000000);

    // 6: asynchronous reset mid-frame
    drive(1'b1, 12'd397, 12'd100);
    drive(1'b1, 12'd397, 12'd100);
    chk("t6.pre", {7'd0, disp_data_vld, disp_data}, {8'h01, 24'h00FF00});
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6.rst.dat", {8'd0, disp_data}, 32'd0);
    chk("t6.rst.vld", {31'd0, disp_data_vld}, 32'd0);
    chk("t6.rst.fcnt", {16'd0, frame_cnt}, 32'd0);
    disp_data_req = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mode = 2'd0;
    scroll_en = 1'b1;
    pix("t6.fs", 12'd0, 12'd0, 24'h000000);
    chk("t6.fcnt", {16'd0, frame_cnt}, 32'd1);
    scroll_en = 1'b0;
    pix("t6.off1", 12'd399, 12'd0, 24'h0000FF);
    pix("t6.grid", 12'd398, 12'd0, 24'h000000);

    // frame counter wrap
    repeat (65534) drive(1'b1, 12'd0, 12'd0);
    chk("wrap.ffff", {16'd0, frame_cnt}, 32'h0000FFFF);
    drive(1'b1, 12'd0, 12'd0);
    chk("wrap.zero", {16'd0, frame_cnt}, 32'd0);
    drive(1'b0, 12'd0, 12'd0);
    drive(1'b0, 12'd0, 12'd0);
    chk("wrap.idle", {16'd0, frame_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
